// File: rtl/serdesphy_ana_pll_pkg.sv
// Shared types and helpers for the PLL charge-pump / loop-filter model.
package serdesphy_ana_pll_pkg;

  typedef enum logic [1:0] {
    StOff,
    StPrecharge,
    StActive
  } pll_state_e;

  // cp_current select to base pump current in LSBs per cycle.
  function automatic logic [2:0] base_current(input logic [1:0] sel);
    logic [2:0] cur;
    cur = 3'd0;
    unique case (sel)
      2'd0:    cur = 3'd0;
      2'd1:    cur = 3'd1;
      2'd2:    cur = 3'd2;
      2'd3:    cur = 3'd4;
      default: cur = 3'd0;
    endcase
    return cur;
  endfunction

  // Clamp a signed value into the code range [0, max_code].
  function automatic int clamp_code(input int val, input int max_code);
    int res;
    res = val;
    if (val < 0) begin
      res = 0;
    end else if (val > max_code) begin
      res = max_code;
    end
    return res;
  endfunction

endpackage

// File: rtl/serdesphy_ana_pll_run_detect.sv
// Tracks consecutive same-direction pump cycles and raises a sticky runaway flag.
module serdesphy_ana_pll_run_detect
  import serdesphy_ana_pll_pkg::*;
#(
  parameter int unsigned MAX_RUN = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic advance,
  input  logic pump_up,
  input  logic pump_dn,
  output logic runaway
);

  localparam int unsigned CntW = $clog2(MAX_RUN + 1);
  localparam logic [CntW-1:0] RunMax = CntW'(MAX_RUN);

  logic [CntW-1:0] run_q, run_d;
  // Last nonzero direction: 2'b01 up, 2'b10 down, 2'b00 none yet.
  logic [1:0] last_dir_q, last_dir_d;
  logic [1:0] dir_now;
  logic runaway_q, runaway_d;

  assign dir_now = {pump_dn, pump_up};

  // Run-length next state; frozen when neither clear nor advance.
  always_comb begin
    run_d      = run_q;
    last_dir_d = last_dir_q;
    runaway_d  = runaway_q;
    if (clear) begin
      run_d      = '0;
      last_dir_d = 2'b00;
      runaway_d  = 1'b0;
    end else if (advance) begin
      if (dir_now == 2'b00) begin
        run_d = '0;
      end else begin
        if (dir_now != last_dir_q) begin
          run_d = CntW'(1);
        end else if (run_q != RunMax) begin
          run_d = run_q + 1'b1;
        end
        last_dir_d = dir_now;
      end
      if (run_d == RunMax) begin
        runaway_d = 1'b1;
      end
    end
  end

  // Run-length state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= '0;
      last_dir_q <= 2'b00;
      runaway_q  <= 1'b0;
    end else begin
      run_q      <= run_d;
      last_dir_q <= last_dir_d;
      runaway_q  <= runaway_d;
    end
  end

  assign runaway = runaway_q;

endmodule

// File: rtl/serdesphy_ana_pll_cp_filter.sv
// Charge pump + loop filter model: integrates PFD pulses into a saturating
// capacitor code, adds a one-cycle proportional kick, and drives the VCO word.
module serdesphy_ana_pll_cp_filter
  import serdesphy_ana_pll_pkg::*;
#(
  parameter int unsigned CTRL_W         = 10,
  parameter int unsigned INIT_CODE      = 512,
  parameter int unsigned PRECHARGE_STEP = 16,
  parameter int unsigned GAIN_SHIFT     = 0,
  parameter int unsigned PROP_SHIFT     = 2,
  parameter int unsigned LEAK_PERIOD    = 0,
  parameter int unsigned MAX_RUN        = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              hold,
  input  logic [1:0]        cp_current,
  input  logic              up_pulse,
  input  logic              down_pulse,
  output logic [CTRL_W-1:0] vctrl,
  output logic              ready,
  output logic              sat_hi,
  output logic              sat_lo,
  output logic              runaway,
  output logic              charge_out
);

  // Signed headroom so integ +/- step never wraps before clamping.
  localparam int unsigned SW = CTRL_W + 2;
  localparam int MaxCode = int'((1 << CTRL_W) - 1);
  localparam logic [CTRL_W-1:0] InitCode = CTRL_W'(INIT_CODE);
  localparam logic [CTRL_W-1:0] MaxCodeW = '1;
  localparam int unsigned LeakW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
  localparam logic [LeakW-1:0] LeakTc = LeakW'((LEAK_PERIOD > 0) ? LEAK_PERIOD - 1 : 0);

  pll_state_e state_q, state_d;
  logic [1:0] cur_q;
  logic [CTRL_W-1:0] integ_q, integ_d, vctrl_q, vctrl_d;
  logic [LeakW-1:0] leak_q, leak_d, leak_wrap;
  logic ready_q, ready_d, sat_hi_q, sat_hi_d, sat_lo_q, sat_lo_d, charge_q, charge_d;

  logic pump_up, pump_dn, pump_active, loop_run, run_clear;
  logic signed [SW-1:0] step_s, prop_s, acc_s, out_s;
  logic [CTRL_W-1:0] integ_pump, vctrl_pump;

  assign pump_up     = up_pulse & ~down_pulse;
  assign pump_dn     = down_pulse & ~up_pulse;
  assign pump_active = (state_q == StActive) & enable;
  assign loop_run    = pump_active & ~hold;
  assign run_clear   = ~pump_active;
  assign leak_wrap   = (leak_q == LeakTc) ? '0 : leak_q + 1'b1;

  // Pumped integrator value and VCO word including the proportional kick.
  always_comb begin
    step_s = $signed({{(SW - 3){1'b0}}, base_current(cur_q)}) << GAIN_SHIFT;
    prop_s = step_s << PROP_SHIFT;
    acc_s  = $signed({2'b00, integ_q});
    if (pump_up) begin
      acc_s = acc_s + step_s;
    end else if (pump_dn) begin
      acc_s = acc_s - step_s;
    end
    integ_pump = CTRL_W'(clamp_code(int'(acc_s), MaxCode));
    out_s = $signed({2'b00, integ_pump});
    if (pump_up) begin
      out_s = out_s + prop_s;
    end else if (pump_dn) begin
      out_s = out_s - prop_s;
    end
    vctrl_pump = CTRL_W'(clamp_code(int'(out_s), MaxCode));
  end

  // FSM next state and loop-filter datapath.
  always_comb begin
    state_d  = state_q;
    integ_d  = integ_q;
    vctrl_d  = vctrl_q;
    leak_d   = leak_q;
    charge_d = 1'b0;
    if (!enable) begin
      state_d = StOff;
      integ_d = '0;
      vctrl_d = '0;
      leak_d  = '0;
    end else begin
      unique case (state_q)
        StOff: begin
          state_d = StPrecharge;
          integ_d = '0;
          vctrl_d = '0;
          leak_d  = '0;
        end
        StPrecharge: begin
          if (32'(InitCode - integ_q) > PRECHARGE_STEP) begin
            integ_d = integ_q + CTRL_W'(PRECHARGE_STEP);
          end else begin
            integ_d = InitCode;
          end
          vctrl_d = integ_d;
          if (integ_d == InitCode) begin
            state_d = StActive;
          end
        end
        StActive: begin
          if (hold) begin
            vctrl_d = integ_q;
          end else if (pump_up || pump_dn) begin
            integ_d  = integ_pump;
            vctrl_d  = vctrl_pump;
            charge_d = (cur_q != 2'd0);
            if (LEAK_PERIOD > 0) begin
              leak_d = leak_wrap;
            end
          end else begin
            if (LEAK_PERIOD > 0) begin
              leak_d = leak_wrap;
              // Leak one LSB toward the precharge target at terminal count.
              if (leak_q == LeakTc) begin
                if (integ_q < InitCode) begin
                  integ_d = integ_q + 1'b1;
                end else if (integ_q > InitCode) begin
                  integ_d = integ_q - 1'b1;
                end
              end
            end
            vctrl_d = integ_d;
          end
        end
        default: begin
          state_d = StOff;
          integ_d = '0;
          vctrl_d = '0;
          leak_d  = '0;
        end
      endcase
    end
    ready_d  = (state_d == StActive);
    sat_hi_d = (integ_d == MaxCodeW);
    sat_lo_d = (state_d == StActive) && (integ_d == '0);
  end

  // State, integrator and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StOff;
      cur_q    <= 2'd0;
      integ_q  <= '0;
      vctrl_q  <= '0;
      leak_q   <= '0;
      ready_q  <= 1'b0;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
      charge_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cp_current;
      integ_q  <= integ_d;
      vctrl_q  <= vctrl_d;
      leak_q   <= leak_d;
      ready_q  <= ready_d;
      sat_hi_q <= sat_hi_d;
      sat_lo_q <= sat_lo_d;
      charge_q <= charge_d;
    end
  end

  serdesphy_ana_pll_run_detect #(
    .MAX_RUN(MAX_RUN)
  ) u_run_detect (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (run_clear),
    .advance(loop_run),
    .pump_up(pump_up),
    .pump_dn(pump_dn),
    .runaway(runaway)
  );

  assign vctrl      = vctrl_q;
  assign ready      = ready_q;
  assign sat_hi     = sat_hi_q;
  assign sat_lo     = sat_lo_q;
  assign charge_out = charge_q;

endmodule

// File: tb/tb_serdesphy_ana_pll_cp_filter.sv
// Bench for the charge pump / loop filter: directed scenarios with literal
// expectations, then randomized traffic checked against an integer model.
module tb_serdesphy_ana_pll_cp_filter;

  localparam int CW     = 10;
  localparam int INIT   = 512;
  localparam int PSTEP  = 16;
  localparam int GS     = 0;
  localparam int PS     = 2;
  localparam int LP     = 8;
  localparam int MAXRUN = 64;
  localparam int MAXC   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          hold = 1'b0;
  logic [1:0]    cp_current = 2'd0;
  logic          up_pulse = 1'b0;
  logic          down_pulse = 1'b0;
  logic [CW-1:0] vctrl;
  logic          ready, sat_hi, sat_lo, runaway, charge_out;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: mode 0 off, 1 precharging, 2 running.
  int m_mode = 0, m_integ = 0, m_vctrl = 0, m_ready = 0, m_sathi = 0, m_satlo = 0;
  int m_runaway = 0, m_charge = 0, m_cur = 0, m_leak = 0, m_run = 0, m_prev = 0;

  serdesphy_ana_pll_cp_filter #(
    .CTRL_W        (CW),
    .INIT_CODE     (INIT),
    .PRECHARGE_STEP(PSTEP),
    .GAIN_SHIFT    (GS),
    .PROP_SHIFT    (PS),
    .LEAK_PERIOD   (LP),
    .MAX_RUN       (MAXRUN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .hold      (hold),
    .cp_current(cp_current),
    .up_pulse  (up_pulse),
    .down_pulse(down_pulse),
    .vctrl     (vctrl),
    .ready     (ready),
    .sat_hi    (sat_hi),
    .sat_lo    (sat_lo),
    .runaway   (runaway),
    .charge_out(charge_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int clampi(input int v);
    return (v < 0) ? 0 : ((v > MAXC) ? MAXC : v);
  endfunction

  task automatic model_clear();
    m_integ = 0; m_vctrl = 0; m_leak = 0; m_run = 0; m_prev = 0; m_runaway = 0;
  endtask

  // One clock of the loop filter, evaluated from the sampled inputs.
  task automatic model_step();
    int dir, step;
    if (!rst_n) begin
      m_mode = 0; model_clear();
      m_ready = 0; m_sathi = 0; m_satlo = 0; m_charge = 0; m_cur = 0;
      return;
    end
    dir  = (up_pulse && !down_pulse) ? 1 : ((down_pulse && !up_pulse) ? -1 : 0);
    step = (m_cur == 0) ? 0 : ((1 << (m_cur - 1)) << GS);
    m_charge = 0;
    if (!enable) begin
      m_mode = 0; model_clear();
    end else if (m_mode == 0) begin
      m_mode = 1; model_clear();
    end else if (m_mode == 1) begin
      m_integ = m_integ + (((INIT - m_integ) < PSTEP) ? (INIT - m_integ) : PSTEP);
      m_vctrl = m_integ;
      if (m_integ == INIT) m_mode = 2;
    end else if (hold) begin
      m_vctrl = m_integ;
    end else begin
      if (dir != 0) begin
        m_integ  = clampi(m_integ + dir * step);
        m_vctrl  = clampi(m_integ + dir * (step << PS));
        m_charge = (m_cur != 0) ? 1 : 0;
        m_run    = (dir == m_prev) ? ((m_run + 1 > MAXRUN) ? MAXRUN : m_run + 1) : 1;
        m_prev   = dir;
      end else begin
        if (m_leak == LP - 1) begin
          if (m_integ < INIT) m_integ = m_integ + 1;
          else if (m_integ > INIT) m_integ = m_integ - 1;
        end
        m_vctrl = m_integ;
        m_run   = 0;
      end
      m_leak = (m_leak + 1) % LP;
      if (m_run == MAXRUN) m_runaway = 1;
    end
    m_ready = (m_mode == 2) ? 1 : 0;
    m_sathi = (m_integ == MAXC) ? 1 : 0;
    m_satlo = (m_mode == 2 && m_integ == 0) ? 1 : 0;
    m_cur   = int'(cp_current);
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // Every cycle, outputs must match the model.
  initial forever begin
    @(negedge clk);
    check("vctrl", int'(vctrl), m_vctrl);
    check("ready", int'(ready), m_ready);
    check("sat_hi", int'(sat_hi), m_sathi);
    check("sat_lo", int'(sat_lo), m_satlo);
    check("runaway", int'(runaway), m_runaway);
    check("charge_out", int'(charge_out), m_charge);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call right after raising enable; counts edges after the sampling edge.
  task automatic wait_ready(output int cycles);
    cycles = 0;
    tick();
    while (!ready && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    int cyc;
    int bias, pu, pd;
    repeat (3) tick();
    check("rst_vctrl", int'(vctrl), 0);
    check("rst_ready", int'(ready), 0);
    check("rst_runaway", int'(runaway), 0);
    check("rst_charge", int'(charge_out), 0);
    rst_n = 1'b1;
    tick();

    // Precharge to INIT_CODE.
    enable = 1'b1;
    wait_ready(cyc);
    check("precharge_cycles", cyc, 32);
    check("precharge_vctrl", int'(vctrl), 512);

    // Both pulses cancel.
    up_pulse = 1'b1; down_pulse = 1'b1;
    repeat (10) tick();
    check("both_vctrl", int'(vctrl), 512);
    check("both_charge", int'(charge_out), 0);

    // Single UP pulse at max current: kick then settle.
    up_pulse = 1'b0; down_pulse = 1'b0; cp_current = 2'd3;
    tick();
    up_pulse = 1'b1;
    tick();
    check("kick_vctrl", int'(vctrl), 532);
    check("kick_charge", int'(charge_out), 1);
    up_pulse = 1'b0;
    tick();
    check("settle_vctrl", int'(vctrl), 516);
    check("settle_charge", int'(charge_out), 0);

    // Leak walks integ back to INIT_CODE.
    repeat (40) tick();
    check("leak_vctrl", int'(vctrl), 512);

    // Hold freezes the loop.
    hold = 1'b1; down_pulse = 1'b1;
    repeat (20) tick();
    check("hold_vctrl", int'(vctrl), 512);
    check("hold_charge", int'(charge_out), 0);
    hold = 1'b0;

    // Continuous DOWN: runaway at 64th cycle, floor at 0.
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (i == 63) check("runaway_63", int'(runaway), 0);
      if (i == 64) check("runaway_64", int'(runaway), 1);
    end
    check("floor_vctrl", int'(vctrl), 0);
    check("floor_sat_lo", int'(sat_lo), 1);
    enable = 1'b0; down_pulse = 1'b0;
    tick();
    check("off_runaway", int'(runaway), 0);
    check("off_ready", int'(ready), 0);
    check("off_sat_lo", int'(sat_lo), 0);

    // Drop enable mid-precharge.
    enable = 1'b1;
    repeat (10) tick();
    check("mid_pre_vctrl", int'(vctrl), 144);
    enable = 1'b0;
    tick();
    check("abort_ready", int'(ready), 0);
    check("abort_vctrl", int'(vctrl), 0);

    // Asynchronous reset while running.
    enable = 1'b1;
    repeat (40) tick();
    rst_n = 1'b0;
    #1;
    check("async_vctrl", int'(vctrl), 0);
    check("async_ready", int'(ready), 0);
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_ready", int'(ready), 0);

    // Drive to the ceiling.
    wait_ready(cyc);
    up_pulse = 1'b1;
    repeat (200) tick();
    check("ceil_vctrl", int'(vctrl), MAXC);
    check("ceil_sat_hi", int'(sat_hi), 1);
    up_pulse = 1'b0;

    // Randomized traffic with slowly changing direction bias.
    bias = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 400 == 0) bias = int'($urandom_range(0, 2));
      pu = (bias == 0) ? 80 : ((bias == 1) ? 15 : 40);
      pd = (bias == 1) ? 80 : ((bias == 0) ? 15 : 40);
      enable     = ($urandom_range(0, 299) != 0);
      hold       = ($urandom_range(0, 19) == 0);
      up_pulse   = ($urandom_range(0, 99) < pu);
      down_pulse = ($urandom_range(0, 99) < pd);
      if ($urandom_range(0, 15) == 0) cp_current = 2'($urandom_range(0, 3));
      tick();
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
